// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
// Byte type and FIFO operation encoding used by RTL and bench.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  typedef enum logic [2:0] {
    NONE,
    PUSH,
    POP,
    PUSH_POP,
    FLUSH
  } fifo_op_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Byte stream bundle between UART receiver, buffer and consumer.
// slave is the buffer view, master is the environment view.
interface uart_rx_fifo_if;
  import uart_pkg::*;

  uart_byte_t rx_data;
  logic       rx_valid;
  uart_byte_t rd_data;
  logic       rd_valid;
  logic       rd_ready;

  modport master (
    output rx_data,
    output rx_valid,
    output rd_ready,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rd_ready,
    output rd_data,
    output rd_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO.
// Full/empty are left to the caller, which sees the occupancy count.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wrPtr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Head is masked to zero when empty so reset shows a clean byte.
  assign rdata = (cnt == '0) ? '0 : mem[rdPtr];
  assign count = cnt;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver.
// Edge-detects frame-valid, arbitrates push/pop/flush, tracks drops.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ALMOST_FULL = 12,
  parameter int DROP_CNT_W  = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_fifo_if.slave         bus,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count,
  input  logic                  overflow_clr,
  input  logic                  flush
);

  logic       rxValidQ;
  logic       pushReq;
  logic       popReq;
  logic       drop;
  logic       fifoPush;
  logic       fifoPop;
  logic       fifoFlush;
  fifo_op_t   op;
  uart_byte_t headByte;

  // Reset to one so a level already high at release is not a new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxValidQ <= 1'b1;
    end else begin
      rxValidQ <= bus.rx_valid;
    end
  end

  assign pushReq = bus.rx_valid & ~rxValidQ;
  assign popReq  = bus.rd_valid & bus.rd_ready;

  always_comb begin
    op   = NONE;
    drop = 1'b0;
    unique case (1'b1)
      flush: begin
        op = FLUSH;
      end
      !flush && pushReq && popReq: begin
        op = PUSH_POP;
      end
      !flush && pushReq && !popReq && !full: begin
        op = PUSH;
      end
      !flush && pushReq && !popReq && full: begin
        drop = 1'b1;
      end
      !flush && !pushReq && popReq: begin
        op = POP;
      end
      default: begin
        op = NONE;
      end
    endcase
  end

  assign fifoPush  = (op == PUSH) || (op == PUSH_POP);
  assign fifoPop   = (op == POP) || (op == PUSH_POP);
  assign fifoFlush = (op == FLUSH);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifoPush),
    .pop   (fifoPop),
    .flush (fifoFlush),
    .wdata (bus.rx_data),
    .rdata (headByte),
    .count (count)
  );

  // A drop in the clear cycle wins and restarts the tally at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (overflow_clr) begin
        drop_count <= DROP_CNT_W'(1);
      end else if (!(&drop_count)) begin
        drop_count <= drop_count + DROP_CNT_W'(1);
      end
    end else if (overflow_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (count >= CW'(ALMOST_FULL));
  assign bus.rd_valid = ~empty;
  assign bus.rd_data  = headByte;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo.
// Stimulus queues expected bytes; a negedge monitor checks every pop.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic [7:0] drop_count;
  logic       overflow_clr;
  logic       flush;

  int nChecks;
  int nFail;
  int nPops;

  uart_byte_t sb[$];

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(
    .DEPTH       (16),
    .ALMOST_FULL (12),
    .DROP_CNT_W  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .overflow_clr (overflow_clr),
    .flush        (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input bit accept);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    if (accept) sb.push_back(b);
    tick();
    bus.rx_valid = 1'b0;
    tick();
  endtask

  task automatic drain(input string nm);
    int i;
    bus.rd_ready = 1'b1;
    i = 0;
    while (!empty && i < 40) begin
      tick();
      i++;
    end
    bus.rd_ready = 1'b0;
    chk(nm, int'(empty), 1);
  endtask

  always @(negedge clk) begin
    if (!rst && !flush && bus.rd_valid && bus.rd_ready) begin
      nPops++;
      nChecks++;
      if (sb.size() == 0) begin
        nFail++;
        $display("FAIL pop_unexpected: got 0x%0h required no byte",
                 bus.rd_data);
      end else begin
        automatic uart_byte_t exp = sb.pop_front();
        if (bus.rd_data != exp) begin
          nFail++;
          $display("FAIL pop_data: got 0x%0h required 0x%0h",
                   bus.rd_data, exp);
        end
      end
    end
  end

  initial begin
    nChecks      = 0;
    nFail        = 0;
    nPops        = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    overflow_clr = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b1;
    bus.rd_ready = 1'b0;

    // Reset with rx_valid held high across release
    repeat (3) tick();
    chk("rst_count", int'(count), 0);
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_rd_data", int'(bus.rd_data), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    repeat (20) tick();
    chk("hold_count", int'(count), 0);
    chk("hold_empty", int'(empty), 1);
    chk("hold_full", int'(full), 0);
    chk("hold_afull", int'(almost_full), 0);
    chk("hold_drop", int'(drop_count), 0);
    bus.rx_valid = 1'b0;
    tick();

    // Held-high level gives one push, FWFT next cycle
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    sb.push_back(8'hA5);
    tick();
    chk("a5_count", int'(count), 1);
    chk("a5_rd_valid", int'(bus.rd_valid), 1);
    chk("a5_rd_data", int'(bus.rd_data), 8'hA5);
    repeat (4) tick();
    chk("a5_held_count", int'(count), 1);
    bus.rx_valid = 1'b0;
    tick();
    bus.rx_data  = 8'h3C;
    bus.rx_valid = 1'b1;
    sb.push_back(8'h3C);
    repeat (5) tick();
    bus.rx_valid = 1'b0;
    tick();
    chk("3c_count", int'(count), 2);
    chk("3c_head", int'(bus.rd_data), 8'hA5);
    drain("drain1_empty");

    // Fill to full, watch thresholds, then two drops
    for (int i = 0; i < 16; i++) begin
      sendByte(8'(i), 1'b1);
      chk("fill_count", int'(count), i + 1);
      chk("fill_afull", int'(almost_full), int'(i + 1 >= 12));
      chk("fill_full", int'(full), int'(i + 1 == 16));
    end
    sendByte(8'h10, 1'b0);
    sendByte(8'h11, 1'b0);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_drop", int'(drop_count), 2);
    chk("ovf_count", int'(count), 16);

    // Push and pop together while full
    bus.rx_data  = 8'h20;
    bus.rx_valid = 1'b1;
    bus.rd_ready = 1'b1;
    sb.push_back(8'h20);
    tick();
    bus.rx_valid = 1'b0;
    bus.rd_ready = 1'b0;
    chk("pp_count", int'(count), 16);
    chk("pp_drop", int'(drop_count), 2);
    chk("pp_head", int'(bus.rd_data), 8'h01);
    tick();
    drain("drain2_empty");

    // Clear versus simultaneous drop
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("clr_flag", int'(overflow), 0);
    chk("clr_drop", int'(drop_count), 0);
    for (int i = 0; i < 16; i++) sendByte(8'(8'h30 + i), 1'b1);
    chk("refill_full", int'(full), 1);
    bus.rx_data  = 8'h40;
    bus.rx_valid = 1'b1;
    overflow_clr = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    overflow_clr = 1'b0;
    chk("clrdrop_flag", int'(overflow), 1);
    chk("clrdrop_drop", int'(drop_count), 1);
    tick();
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("clr2_flag", int'(overflow), 0);
    chk("clr2_drop", int'(drop_count), 0);
    drain("drain3_empty");

    // Flush with a coincident edge
    for (int i = 0; i < 5; i++) sendByte(8'(8'h50 + i), 1'b1);
    chk("pre_flush_count", int'(count), 5);
    bus.rx_data  = 8'h66;
    bus.rx_valid = 1'b1;
    flush        = 1'b1;
    sb.delete();
    tick();
    flush        = 1'b0;
    bus.rx_valid = 1'b0;
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_overflow", int'(overflow), 0);
    chk("flush_drop", int'(drop_count), 0);
    tick();
    sendByte(8'h77, 1'b1);
    chk("post_flush_count", int'(count), 1);
    chk("post_flush_data", int'(bus.rd_data), 8'h77);
    drain("drain4_empty");

    tick();
    chk("sb_leftover", sb.size(), 0);
    chk("pop_total", nPops, 36);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
